// File: rtl/pixel_log2_iter.sv
// rtl/pixel_log2_iter.sv - iterative log2 of one unsigned pixel, 8.8 sign-magnitude result
module pixel_log2_iter #(
  parameter int XLEN_PIXEL = 8,
  parameter int ITERATOR   = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [XLEN_PIXEL-1:0]   pixel,
  output logic                    busy,
  output logic                    done,
  output logic                    zero_err,
  output logic [2*XLEN_PIXEL-1:0] log_out,
  output logic [3:0]              rom_idx,
  input  logic [2*XLEN_PIXEL-1:0] rom_val
);

  localparam int W = 2 * XLEN_PIXEL;
  localparam logic [3:0] LP_LAST = 4'(ITERATOR);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_NORM = 3'd1;
  localparam logic [2:0] S_LOOK = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            r_state;
  logic [XLEN_PIXEL-1:0] r_pixel;
  logic [W-1:0]          r_m;
  logic [7:0]            r_acc;
  logic [3:0]            r_i;
  logic [2:0]            r_p;
  logic [W-1:0]          r_log_out;
  logic                  r_zero_err;

  logic [2:0]            w_lead;
  logic [XLEN_PIXEL-1:0] w_shift;
  logic [W-1:0]          w_trial;
  logic                  w_take;
  logic [7:0]            w_acc_sum;
  logic                  w_unused_rom;

  // Leading-one position of the captured pixel; the highest set bit wins.
  always_comb begin
    w_lead = 3'd0;
    for (int k = 0; k < XLEN_PIXEL; k++) begin
      if (r_pixel[k]) w_lead = 3'(k);
    end
  end

  // Normalisation shift, trial subtraction and conditional accumulate.
  always_comb begin
    w_shift   = r_pixel << (3'd7 - w_lead);
    w_trial   = r_m - (r_m >> r_i);
    w_take    = w_trial[W-1];
    w_acc_sum = w_take ? (r_acc + rom_val[7:0]) : r_acc;
  end

  // Table sign and integer bits never contribute: every entry is negative and at most 1.0.
  assign w_unused_rom = &{1'b0, rom_val[W-1:8]};

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign zero_err = r_zero_err;
  assign log_out  = r_log_out;
  assign rom_idx  = ((r_state == S_LOOK) || (r_state == S_ACC)) ? r_i : 4'd0;

  // Control FSM and datapath registers; result registers update on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pixel    <= '0;
      r_m        <= '0;
      r_acc      <= '0;
      r_i        <= '0;
      r_p        <= '0;
      r_log_out  <= '0;
      r_zero_err <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_pixel <= pixel;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_pixel == '0) begin
            r_zero_err <= 1'b1;
            r_log_out  <= {1'b1, {(W-1){1'b0}}};
            r_state    <= S_DONE;
          end else begin
            r_p     <= w_lead;
            r_m     <= {w_shift, {XLEN_PIXEL{1'b0}}};
            r_acc   <= '0;
            r_i     <= 4'd1;
            r_state <= S_LOOK;
          end
        end
        S_LOOK: begin
          r_state <= S_ACC;
        end
        S_ACC: begin
          if (w_take) r_m <= w_trial;
          r_acc <= w_acc_sum;
          if (r_i == LP_LAST) begin
            r_log_out  <= {{(W-11){1'b0}}, r_p, w_acc_sum};
            r_zero_err <= 1'b0;
            r_state    <= S_DONE;
          end else begin
            r_i     <= r_i + 4'd1;
            r_state <= S_LOOK;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_log2_iter.sv
// tb/tb_pixel_log2_iter.sv - directed bench for pixel_log2_iter with a log_mod table model
module tb_pixel_log2_iter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  pixel;
  logic        busy;
  logic        done;
  logic        zero_err;
  logic [15:0] log_out;
  logic [3:0]  rom_idx;
  logic [15:0] rom_val;

  int n_total;
  int n_bad;
  logic [3:0] idx_seq [0:31];

  pixel_log2_iter #(.XLEN_PIXEL(8), .ITERATOR(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pixel    (pixel),
    .busy     (busy),
    .done     (done),
    .zero_err (zero_err),
    .log_out  (log_out),
    .rom_idx  (rom_idx),
    .rom_val  (rom_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Truncated magnitudes of log2(1-2^-i) in 8 fraction bits, sign bit set.
  function automatic logic [15:0] tbl(input logic [3:0] i);
    case (i)
      4'd1:    tbl = 16'h8100;
      4'd2:    tbl = 16'h806A;
      4'd3:    tbl = 16'h8031;
      4'd4:    tbl = 16'h8017;
      4'd5:    tbl = 16'h800B;
      4'd6:    tbl = 16'h8005;
      4'd7:    tbl = 16'h8002;
      4'd8:    tbl = 16'h8001;
      default: tbl = 16'h0000;
    endcase
  endfunction

  // Registered table read, one cycle behind rom_idx.
  always_ff @(posedge clk) rom_val <= tbl(rom_idx);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Start one operation, wait for done, check result, latency and return to idle.
  task automatic run_op(input string tag, input logic [7:0] px, input logic [15:0] exp_log,
                        input logic exp_zerr, input int exp_cyc, input bit poke);
    int cyc;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    pixel = px;
    @(posedge clk);
    #1 start = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc < 32) idx_seq[cyc] = rom_idx;
      if (done) begin
        seen = 1'b1;
      end else if (poke && cyc == 5) begin
        start = 1'b1;
        pixel = 8'd2;
        @(posedge clk);
        #1 start = 1'b0;
        pixel = px;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_log_out"}, 32'(log_out), 32'(exp_log));
    chk({tag, "_zero_err"}, 32'(zero_err), 32'(exp_zerr));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    if (poke) begin
      start = 1'b1;
      pixel = 8'd2;
    end
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_done_after"}, 32'(done), 32'd0);
    chk({tag, "_held"}, 32'(log_out), 32'(exp_log));
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    start   = 1'b0;
    pixel   = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_zero_err", 32'(zero_err), 32'd0);
    chk("rst_log_out", 32'(log_out), 32'd0);
    chk("rst_rom_idx", 32'(rom_idx), 32'd0);
    rst_n = 1'b1;

    run_op("px1", 8'd1, 16'h0000, 1'b0, 18, 1'b0);
    run_op("px2", 8'd2, 16'h0100, 1'b0, 18, 1'b0);
    run_op("px128", 8'd128, 16'h0700, 1'b0, 18, 1'b0);
    run_op("px3", 8'd3, 16'h0192, 1'b0, 18, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      logic [3:0] e;
      e = (c == 1 || c == 18) ? 4'd0 : 4'(c / 2);
      chk($sformatf("px3_rom_idx_c%0d", c), 32'(idx_seq[c]), 32'(e));
    end
    run_op("px255", 8'd255, 16'h07C5, 1'b0, 18, 1'b0);
    run_op("px0", 8'd0, 16'h8000, 1'b1, 2, 1'b0);
    run_op("px2_after0", 8'd2, 16'h0100, 1'b0, 18, 1'b0);

    // Reset at cycle 7 of a pixel=3 run, with start asserted alongside.
    @(negedge clk);
    start = 1'b1;
    pixel = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(negedge clk);
    chk("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_log_out", 32'(log_out), 32'd0);
    chk("mid_rst_zero_err", 32'(zero_err), 32'd0);
    chk("mid_rst_rom_idx", 32'(rom_idx), 32'd0);
    begin
      int d;
      d = 0;
      for (int c = 0; c < 25; c++) begin
        @(negedge clk);
        if (done || busy) d++;
      end
      chk("mid_rst_no_activity", 32'(d), 32'd0);
    end

    run_op("px255_poke", 8'd255, 16'h07C5, 1'b0, 18, 1'b1);
    run_op("px3_after", 8'd3, 16'h0192, 1'b0, 18, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
